// File: rtl/berzerk_input_cond.sv
// Berzerk control conditioning: synchronises and debounces the merged
// joystick bits, optionally neutralises opposing directions, and turns coin
// presses into queued fixed-width coin pulses that honour CPU pause.
module berzerk_input_cond #(
  parameter int unsigned DEB_CYCLES   = 40000,
  parameter int unsigned COIN_ON      = 4000000,
  parameter int unsigned COIN_OFF     = 4000000,
  parameter int unsigned COIN_MAX     = 3,
  parameter int unsigned SOCD_NEUTRAL = 1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [8:0] joy_in,
  input  logic       pause_cpu,
  output logic       m_right,
  output logic       m_left,
  output logic       m_down,
  output logic       m_up,
  output logic       m_fire,
  output logic       m_start1,
  output logic       m_start2,
  output logic       m_pause,
  output logic       coin_out,
  output logic [1:0] coin_pending,
  output logic       coin_overflow
);

  localparam int unsigned MAX_AB = (DEB_CYCLES > COIN_ON) ? DEB_CYCLES : COIN_ON;
  localparam int unsigned MAX_C  = (MAX_AB > COIN_OFF) ? MAX_AB : COIN_OFF;
  localparam int unsigned CW     = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);
  localparam logic [1:0]  PMAX   = 2'(COIN_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } coin_state_t;

  logic [8:0]    sync1_q, sync2_q;
  logic [8:0]    stable;
  logic [8:0]    masked;
  logic [7:0]    out_q;
  logic          coin_prev_q, coin_rise_q;
  logic [1:0]    pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          coin_start, coin_inc;
  coin_state_t   state_q;
  logic [CW-1:0] timer_q;
  logic          coin_out_q;

  // Two-flop synchroniser on every raw input bit
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= joy_in;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_nodeb
      assign stable = sync2_q;
    end else begin : g_deb
      logic [8:0]    deb_q;
      logic [CW-1:0] cnt_q [9];

      // Per-bit debounce: adopt the synced value after DEB_CYCLES straight mismatches
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          deb_q <= '0;
          for (int unsigned b = 0; b < 9; b++) cnt_q[b] <= '0;
        end else begin
          for (int unsigned b = 0; b < 9; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
              cnt_q[b] <= '0;
            end else if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
              deb_q[b] <= sync2_q[b];
              cnt_q[b] <= '0;
            end else begin
              cnt_q[b] <= cnt_q[b] + CW'(1);
            end
          end
        end
      end

      assign stable = deb_q;
    end
  endgenerate

  // Opposing-direction neutralisation; fire, starts and pause pass untouched
  always_comb begin
    masked = stable;
    if (SOCD_NEUTRAL != 0) begin
      if (stable[3] && stable[2]) masked[3:2] = '0;
      if (stable[1] && stable[0]) masked[1:0] = '0;
    end
  end

  // Output register; coin is excluded because it leaves through the pulse shaper
  always_ff @(posedge clk_sys) begin
    if (reset) out_q <= '0;
    else       out_q <= {masked[8], masked[6:0]};
  end

  assign m_right  = out_q[0];
  assign m_left   = out_q[1];
  assign m_down   = out_q[2];
  assign m_up     = out_q[3];
  assign m_fire   = out_q[4];
  assign m_start1 = out_q[5];
  assign m_start2 = out_q[6];
  assign m_pause  = out_q[7];

  // Registered rising-edge detect on the debounced coin bit
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_prev_q <= 1'b0;
      coin_rise_q <= 1'b0;
    end else begin
      coin_prev_q <= stable[7];
      coin_rise_q <= stable[7] & ~coin_prev_q;
    end
  end

  // Queue bookkeeping: saturating enqueue, dequeue on pulse start, overflow on drop
  always_comb begin
    coin_start = (state_q == S_IDLE) && (pending_q != 2'd0) && !pause_cpu;
    coin_inc   = coin_rise_q && (pending_q < PMAX);
    overflow_d = coin_rise_q && (pending_q == PMAX);
    pending_d  = pending_q;
    if (coin_inc && !coin_start)      pending_d = pending_q + 2'd1;
    else if (!coin_inc && coin_start) pending_d = pending_q - 2'd1;
  end

  // Coin pulse FSM with pause-frozen timer and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      coin_out_q <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        S_IDLE: begin
          if (coin_start) begin
            state_q    <= S_ON;
            timer_q    <= '0;
            coin_out_q <= 1'b1;
          end
        end
        S_ON: begin
          if (!pause_cpu) begin
            if (timer_q == CW'(COIN_ON - 1)) begin
              state_q    <= S_OFF;
              timer_q    <= '0;
              coin_out_q <= 1'b0;
            end else begin
              timer_q <= timer_q + CW'(1);
            end
          end
        end
        S_OFF: begin
          if (!pause_cpu) begin
            if (timer_q == CW'(COIN_OFF - 1)) state_q <= S_IDLE;
            else                              timer_q <= timer_q + CW'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          timer_q    <= '0;
          coin_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign coin_out      = coin_out_q;
  assign coin_pending  = pending_q;
  assign coin_overflow = overflow_q;

endmodule

// File: tb/tb_berzerk_input_cond.sv
// Bench for berzerk_input_cond: directed stimulus, a cycle model built from
// sample windows and pulse-elapsed counts, and literal latency/count checks.
module tb_berzerk_input_cond;

  localparam int unsigned DEB  = 4;
  localparam int unsigned CON  = 8;
  localparam int unsigned COFF = 6;
  localparam int unsigned CMAX = 3;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [8:0] joy_in;
  logic       pause_cpu;
  logic       m_right, m_left, m_down, m_up, m_fire;
  logic       m_start1, m_start2, m_pause;
  logic       coin_out;
  logic [1:0] coin_pending;
  logic       coin_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  berzerk_input_cond #(
    .DEB_CYCLES  (DEB),
    .COIN_ON     (CON),
    .COIN_OFF    (COFF),
    .COIN_MAX    (CMAX),
    .SOCD_NEUTRAL(1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .joy_in       (joy_in),
    .pause_cpu    (pause_cpu),
    .m_right      (m_right),
    .m_left       (m_left),
    .m_down       (m_down),
    .m_up         (m_up),
    .m_fire       (m_fire),
    .m_start1     (m_start1),
    .m_start2     (m_start2),
    .m_pause      (m_pause),
    .coin_out     (coin_out),
    .coin_pending (coin_pending),
    .coin_overflow(coin_overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] h [0:DEB];   // h[0] newest joy_in sample
  logic [8:0] mq;          // debounced value
  logic [7:0] mout;
  logic       mprev, mrise, movf;
  int         mpend;
  bit         mact;        // a pulse (high part + gap) is in progress
  int         mel;         // cycles elapsed in that pulse
  bit         mvalid = 0;

  always @(posedge clk_sys) begin : model
    logic [8:0] soc;
    logic [8:0] nq;
    bit         start;
    bit         all_diff;
    if (reset) begin
      for (int k = 0; k <= DEB; k++) h[k] = '0;
      mq = '0; mout = '0; mprev = 0; mrise = 0; movf = 0;
      mpend = 0; mact = 0; mel = 0; mvalid = 1;
    end else begin
      soc = mq;
      if (mq[3] && mq[2]) soc[3:2] = 2'b00;
      if (mq[1] && mq[0]) soc[1:0] = 2'b00;
      start = !mact && (mpend > 0) && !pause_cpu;
      movf  = mrise && (mpend == CMAX);
      mpend = mpend + ((mrise && mpend < CMAX) ? 1 : 0) - (start ? 1 : 0);
      if (start) begin
        mact = 1; mel = 0;
      end else if (mact && !pause_cpu) begin
        if (mel == CON + COFF - 1) mact = 0;
        else mel++;
      end
      mrise = mq[7] && !mprev;
      mprev = mq[7];
      mout  = {soc[8], soc[6:0]};
      // a bit flips once its last DEB synchronised samples all disagree with it
      nq = mq;
      for (int b = 0; b < 9; b++) begin
        all_diff = 1;
        for (int k = 1; k <= DEB; k++) if (h[k][b] == mq[b]) all_diff = 0;
        if (all_diff) nq[b] = ~mq[b];
      end
      mq = nq;
      for (int k = DEB; k > 0; k--) h[k] = h[k-1];
      h[0] = joy_in;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk_sys) begin
    if (mvalid) begin
      check("cycle",
            int'({m_pause, m_start2, m_start1, m_fire, m_up, m_down, m_left, m_right,
                  coin_out, coin_pending, coin_overflow}),
            int'({mout, (mact && mel < CON), 2'(mpend), movf}));
    end
  end

  // Event counters for pulse/overflow totals
  int   n_pulses = 0, n_ovf = 0, max_pend = 0;
  logic co_prev = 0;
  always @(negedge clk_sys) begin
    if (coin_out && !co_prev) n_pulses++;
    if (coin_overflow) n_ovf++;
    if (int'(coin_pending) > max_pend) max_pend = int'(coin_pending);
    co_prev = coin_out;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic coin_press();
    joy_in[7] = 1'b1;
    tick(6);
    joy_in[7] = 1'b0;
    tick(6);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    int lat, seen, rise, fall, hi;
    reset = 1; joy_in = '0; pause_cpu = 0;
    tick(3);
    check("reset_coin_out", int'(coin_out), 0);
    check("reset_pending", int'(coin_pending), 0);
    check("reset_up", int'(m_up), 0);
    reset = 0;

    // up latency
    joy_in = 9'h008; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (m_up && lat == 0) lat = i;
    end
    check("up_latency", lat, 7);
    joy_in = '0; tick(12);

    // short glitch on fire is swallowed
    joy_in[4] = 1; tick(3); joy_in[4] = 0; seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (m_fire) seen = 1;
    end
    check("fire_glitch", seen, 0);

    // 5-cycle press gets through
    joy_in[4] = 1; rise = 0; fall = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 5) joy_in[4] = 0;
      if (m_fire && rise == 0) rise = i;
      if (!m_fire && rise != 0 && fall == 0) fall = i;
    end
    check("fire_rise", rise, 7);
    check("fire_fall", fall, 12);

    // opposing directions
    joy_in = 9'h00C; tick(12);
    check("socd_ud", int'({m_up, m_down}), 0);
    joy_in = 9'h00F; tick(12);
    check("socd_lr", int'({m_left, m_right}), 0);
    joy_in = 9'h00B; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (m_up && lat == 0) lat = i;
    end
    check("socd_release_up", lat, 7);
    check("socd_lr_still", int'({m_left, m_right}), 0);
    joy_in = '0; tick(12);

    // queued coin held by pause while idle, then pause during the high phase
    pause_cpu = 1;
    coin_press();
    tick(10);
    check("paused_idle_coin_out", int'(coin_out), 0);
    check("paused_idle_pending", int'(coin_pending), 1);
    pause_cpu = 0;
    tick(1);
    check("start_after_pause", int'(coin_out), 1);
    check("pending_after_start", int'(coin_pending), 0);
    hi = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (coin_out) hi++;
    end
    pause_cpu = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (coin_out) hi++;
    end
    pause_cpu = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (!coin_out) break;
      hi++;
    end
    check("paused_on_high", hi, 28);
    tick(20);

    // five presses: one starts at once, three queue, one is dropped
    n_pulses = 0; n_ovf = 0; max_pend = 0;
    coin_press();
    pause_cpu = 1;
    repeat (4) coin_press();
    pause_cpu = 0;
    tick(80);
    check("queue_pulses", n_pulses, 4);
    check("queue_overflows", n_ovf, 1);
    check("queue_max_pending", max_pend, 3);
    check("queue_drained", int'(coin_pending), 0);
    tick(10);

    // reset in the middle of a pulse
    pause_cpu = 1;
    repeat (3) coin_press();
    pause_cpu = 0;
    tick(1);
    check("pre_reset_pending", int'(coin_pending), 2);
    tick(3);
    reset = 1;
    tick(1);
    check("reset_mid_coin_out", int'(coin_out), 0);
    check("reset_mid_pending", int'(coin_pending), 0);
    reset = 0;
    n_pulses = 0;
    tick(40);
    check("no_pulse_after_reset", n_pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
